// File: rtl/bmem_pkg.sv
// Shared types and constants for the bmem line adapter and its line buffer.
package bmem_pkg;

  localparam int BEAT_WIDTH       = 64;
  localparam int BURST_LEN        = 4;
  localparam int LINE_WIDTH       = BEAT_WIDTH * BURST_LEN;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } bmem_adapter_state_t;

endpackage

// File: rtl/bmem_line_buffer.sv
// One cache line of storage: whole-line load for writes, beat-indexed fill for
// reads and a beat-indexed read mux feeding the write burst.
module bmem_line_buffer #(
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int IDX_W      = $clog2(BURST_LEN)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [BEAT_WIDTH*BURST_LEN-1:0] load_line,
  input  logic                            we,
  input  logic [IDX_W-1:0]                widx,
  input  logic [BEAT_WIDTH-1:0]           wbeat,
  input  logic [IDX_W-1:0]                ridx,
  output logic [BEAT_WIDTH-1:0]           rbeat,
  output logic [BEAT_WIDTH*BURST_LEN-1:0] line
);

  logic [BEAT_WIDTH*BURST_LEN-1:0] line_r;

  // Line storage; a full-line load wins over a single-beat fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_r <= '0;
    end else if (load) begin
      line_r <= load_line;
    end else if (we) begin
      line_r[int'(widx)*BEAT_WIDTH +: BEAT_WIDTH] <= wbeat;
    end
  end

  assign rbeat = line_r[int'(ridx)*BEAT_WIDTH +: BEAT_WIDTH];
  assign line  = line_r;

endmodule

// File: rtl/bmem_line_adapter.sv
// CPU-side bmem initiator: turns one 256-bit line read/write into a bmem
// command plus 4-beat burst, one transaction outstanding at a time.
module bmem_line_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = bmem_pkg::BEAT_WIDTH,
  parameter int BURST_LEN  = bmem_pkg::BURST_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           dfp_addr,
  input  logic                            dfp_read,
  input  logic                            dfp_write,
  input  logic [BEAT_WIDTH*BURST_LEN-1:0] dfp_wdata,
  output logic [BEAT_WIDTH*BURST_LEN-1:0] dfp_rdata,
  output logic                            dfp_resp,
  output logic [ADDR_WIDTH-1:0]           bmem_addr,
  output logic                            bmem_read,
  output logic                            bmem_write,
  output logic [BEAT_WIDTH-1:0]           bmem_wdata,
  input  logic                            bmem_ready,
  input  logic [ADDR_WIDTH-1:0]           bmem_raddr,
  input  logic [BEAT_WIDTH-1:0]           bmem_rdata,
  input  logic                            bmem_rvalid
);

  import bmem_pkg::*;

  localparam int LINE_W   = BEAT_WIDTH * BURST_LEN;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_W) - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);

  bmem_adapter_state_t   state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic                  read_r, read_s;
  logic                  write_r, write_s;
  logic [BEAT_WIDTH-1:0] wdata_r, wdata_s;
  logic                  resp_r, resp_s;
  logic [LINE_W-1:0]     rdata_r, rdata_s;

  logic                  buf_load_s;
  logic                  buf_we_s;
  logic [CNT_W-1:0]      buf_ridx_s;
  logic [BEAT_WIDTH-1:0] buf_rbeat_s;
  logic [LINE_W-1:0]     buf_line_s;
  logic [LINE_W-1:0]     merged_line_s;
  logic [ADDR_WIDTH-1:0] aligned_addr_s;
  logic                  addr_hit_s;

  assign aligned_addr_s = dfp_addr & ~OFFSET_MASK;
  assign addr_hit_s     = bmem_rvalid && (bmem_raddr == addr_r);
  // Write bursts preload the beat after the one currently on the bus.
  assign buf_ridx_s     = cnt_r + CNT_ONE;

  bmem_line_buffer #(
    .BEAT_WIDTH(BEAT_WIDTH),
    .BURST_LEN (BURST_LEN),
    .IDX_W     (CNT_W)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load_s),
    .load_line(dfp_wdata),
    .we       (buf_we_s),
    .widx     (cnt_r),
    .wbeat    (bmem_rdata),
    .ridx     (buf_ridx_s),
    .rbeat    (buf_rbeat_s),
    .line     (buf_line_s)
  );

  // Completed read line: buffer contents with the beat arriving this cycle merged in.
  always_comb begin
    merged_line_s = buf_line_s;
    merged_line_s[int'(cnt_r)*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
  end

  // Next-state and next-output logic; outputs are computed for the next state.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    read_s     = 1'b0;
    write_s    = 1'b0;
    wdata_s    = wdata_r;
    resp_s     = 1'b0;
    rdata_s    = rdata_r;
    buf_load_s = 1'b0;
    buf_we_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (dfp_write) begin
          state_s    = WR_DATA;
          addr_s     = aligned_addr_s;
          cnt_s      = {CNT_W{1'b0}};
          buf_load_s = 1'b1;
          write_s    = 1'b1;
          wdata_s    = dfp_wdata[BEAT_WIDTH-1:0];
        end else if (dfp_read) begin
          state_s = RD_CMD;
          addr_s  = aligned_addr_s;
          cnt_s   = {CNT_W{1'b0}};
          read_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          state_s = RD_DATA;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          read_s = 1'b1;
        end
      end
      RD_DATA: begin
        if (addr_hit_s) begin
          buf_we_s = 1'b1;
          if (cnt_r == LAST_BEAT) begin
            state_s = RESP;
            resp_s  = 1'b1;
            rdata_s = merged_line_s;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_s = RD_DATA;
        end
      end
      WR_DATA: begin
        if (bmem_ready) begin
          if (cnt_r == LAST_BEAT) begin
            state_s = RESP;
            resp_s  = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            write_s = 1'b1;
            cnt_s   = cnt_r + CNT_ONE;
            wdata_s = buf_rbeat_s;
          end
        end else begin
          write_s = 1'b1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, latched address and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_WIDTH{1'b0}};
      read_r  <= 1'b0;
      write_r <= 1'b0;
      wdata_r <= {BEAT_WIDTH{1'b0}};
      resp_r  <= 1'b0;
      rdata_r <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      read_r  <= read_s;
      write_r <= write_s;
      wdata_r <= wdata_s;
      resp_r  <= resp_s;
      rdata_r <= rdata_s;
    end
  end

  assign dfp_rdata  = rdata_r;
  assign dfp_resp   = resp_r;
  assign bmem_addr  = addr_r;
  assign bmem_read  = read_r;
  assign bmem_write = write_r;
  assign bmem_wdata = wdata_r;

endmodule

// File: doc/bmem_line_adapter.md
Name: bmem_line_adapter

Overview:
- CPU-side initiator for the banked memory interface.
- Converts single 256-bit cache-line read/write requests from the cache arbiter into bmem command and burst transactions. A read is one command followed by 4 returned beats; a write is 4 consecutive command beats.
- Sits between the cache arbiter (dfp side) and the cpu top-level bmem_* ports.
- One outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- BEAT_WIDTH, 64, bmem data bits per beat.
- BURST_LEN, 4, beats per line. Line width is BEAT_WIDTH*BURST_LEN = 256.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dfp_addr  in  ADDR_WIDTH  line address; low log2(line bytes) bits ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  256  write line; beat k = bits [64k+63:64k]
- dfp_rdata  out  256  assembled read line, valid when dfp_resp
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  ADDR_WIDTH  aligned line address
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_WIDTH  write beat
- bmem_ready  in  1  memory accepts command/beat this cycle
- bmem_raddr  in  ADDR_WIDTH  address tag of returned beat
- bmem_rdata  in  BEAT_WIDTH  returned beat
- bmem_rvalid  in  1  returned beat valid

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0.
  - All outputs 0, including dfp_rdata.
  - Latched address and line buffer cleared.
  - Beats that arrive after reset deassertion for a pre-reset read are dropped, because IDLE ignores rvalid.
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - dfp_write=1 → latch aligned addr and wdata, go to WR_DATA. Write has priority if dfp_read and dfp_write are both high.
  - Else dfp_read=1 → latch addr, go to RD_CMD.
  - Requests are sampled only in IDLE.
- RD_CMD:
  - bmem_read=1, bmem_addr=latched addr.
  - If bmem_ready=1 the command is accepted that edge → RD_DATA, counter=0.
  - Else hold all outputs unchanged next cycle.
- RD_DATA:
  - bmem_read=0.
  - Each cycle with bmem_rvalid=1 and bmem_raddr==latched addr: write bmem_rdata into slot[counter], increment counter.
  - rvalid with non-matching raddr is ignored.
  - On the BURST_LEN-th beat → RESP. Beats need not be contiguous.
- WR_DATA:
  - bmem_write=1, bmem_addr=latched addr, bmem_wdata=slot[counter].
  - Counter advances only on cycles with bmem_ready=1.
  - When the last beat is accepted → RESP. Back-to-back beats appear when ready stays high.
  - bmem_write is never deasserted mid-burst; ready=0 only stalls the burst.
- RESP:
  - dfp_resp=1 for exactly one cycle. For reads, dfp_rdata holds the assembled line.
  - dfp_rdata then holds its value until the next read completes.
  - Next state is IDLE. A new request is not accepted until the following cycle, giving a minimum 1-cycle bubble.
- Latency with ready and rvalid always high:
  - Read: command cycle, then memory latency, then 4 beats, then 1 RESP cycle.
  - Write: 4 beat cycles, then 1 RESP cycle (5 cycles from IDLE exit).
- Addressing: bmem_addr = dfp_addr with low 5 bits cleared. The address is constant for the whole burst.
- Counter width is clog2(BURST_LEN). No wrap occurs inside a burst, because the counter is cleared on state entry.
- Command outputs are registered from state, not combinational from bmem_ready.

Decomposition:
- Shared package bmem_pkg:
  - Constants BEAT_WIDTH, BURST_LEN, LINE_WIDTH, LINE_OFFSET_BITS.
  - typedef line_t (logic [LINE_WIDTH-1:0]) and beat_t.
  - enum bmem_adapter_state_t.
- One natural sub-module: bmem_line_buffer.
  - 256-bit register with beat-indexed write port (reads) and beat-indexed read mux (writes).
  - Adapter FSM and counter live in the top module.

Test Plan:
- Read, ready=1: dfp_read addr 0x1EC0_003C → single bmem_read cycle with bmem_addr=0x1EC0_0020; memory returns 4 beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → dfp_resp 1 cycle with dfp_rdata={0x44..,0x33..,0x22..,0x11..}.
- Read with ready stall and gapped rvalid: ready low 3 cycles → bmem_read held with stable addr; beats separated by idle cycles plus one beat with raddr 0x0000_1000 → stray beat ignored, line correct, exactly one resp.
- Write: dfp_wdata beats 0xA..,0xB..,0xC..,0xD.. at addr 0x0000_0040, ready toggling 1,0,1,1,0,1 → wdata sequence A,B,B,C,D,D with write=1 every cycle; resp 1 cycle after D accepted.
- Simultaneous dfp_read=1 and dfp_write=1 in IDLE → write burst issued first, no bmem_read until after resp.
- Async reset asserted mid-RD_DATA after 2 beats → outputs 0 immediately without a clock edge; remaining 2 beats after reset produce no resp; next read completes normally.
- Back-to-back: write then read held continuously → exactly one resp per request, one idle cycle between resp and next command.
